// File: rtl/audiofifo_mc.sv
// Multichannel audio frame FIFO with look-ahead synchronous-read RAM.
// Sticky underrun/overrun flags, flush, and registered status outputs.
module audiofifo_mc #(
    parameter int WIDTH             = 16,
    parameter int CHANNELS          = 2,
    parameter int DEPTH             = 64,
    parameter int ACCEPT_LIMIT      = DEPTH - 4,
    parameter int NEARLY_FULL_LEVEL = 48,
    parameter bit ZERO_ON_EMPTY     = 1'b1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_write,
    input  logic [CHANNELS*WIDTH-1:0]     in_sample,
    output logic                          in_strobe,
    output logic                          out_write,
    input  logic                          out_strobe,
    output logic [CHANNELS*WIDTH-1:0]     out_sample,
    input  logic                          flush,
    output logic [$clog2(DEPTH):0]        level,
    output logic                          nearly_full,
    output logic                          underrun,
    output logic                          overrun,
    input  logic                          clear_flags
);
    localparam int FW = CHANNELS * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] LIMIT = LW'(ACCEPT_LIMIT);
    localparam logic [LW-1:0] NFULL = LW'(NEARLY_FULL_LEVEL);

    // Asynchronous assertion, deassertion released on clk.
    logic [1:0] rsync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rsync_q <= '0;
        else          rsync_q <= {rsync_q[0], 1'b1};
    end

    assign rst_n = rsync_q[1];

    logic [FW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, la;
    logic [LW-1:0] level_q, level_d;
    logic [FW-1:0] out_q, out_d;
    logic          valid_q, valid_d;
    logic          nf_q, nf_d;
    logic          under_q, under_d, over_q, over_d;
    logic          zero_q, zero_d;
    logic          accept, xfer, under_set, over_set;

    always_comb begin
        accept    = rst_n && in_write && (level_q < LIMIT) && !flush;
        xfer      = valid_q && out_strobe && !flush;
        la        = rd_q + AW'(xfer);
        wr_d      = accept ? wr_q + AW'(1) : wr_q;
        rd_d      = la;
        level_d   = level_q;
        unique case ({accept, xfer})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (flush) begin
            level_d = '0;
            wr_d    = rd_q;
        end
        // A frame landing on the look-ahead slot this edge is not yet readable.
        valid_d   = !flush && (level_d != '0) && !(accept && (wr_q == la));
        nf_d      = level_d >= NFULL;
        under_set = out_strobe && (level_q == '0);
        over_set  = in_write && !accept && !flush;
        under_d   = under_set | (under_q & ~clear_flags);
        over_d    = over_set | (over_q & ~clear_flags);
        zero_d    = (zero_q | under_set) & ~valid_d;
        out_d     = mem[la];
        if (!valid_d && (zero_q || under_set)) begin
            out_d = ZERO_ON_EMPTY ? '0 : out_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_q] <= in_sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            nf_q    <= 1'b0;
            under_q <= 1'b0;
            over_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            nf_q    <= nf_d;
            under_q <= under_d;
            over_q  <= over_d;
            zero_q  <= zero_d;
        end
    end

    assign in_strobe   = accept;
    assign out_write   = valid_q;
    assign out_sample  = out_q;
    assign level       = level_q;
    assign nearly_full = nf_q;
    assign underrun    = under_q;
    assign overrun     = over_q;

endmodule

// File: tb/tb_audiofifo_mc.sv
// Randomized bench for audiofifo_mc against a queue-based frame model.
// Default parameters: 2x16-bit frames, 64 deep, accept limit 60.
module tb_audiofifo_mc;
    localparam int AL = 60;
    localparam int NF = 48;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_write;
    logic [31:0] in_sample;
    logic        in_strobe;
    logic        out_write;
    logic        out_strobe;
    logic [31:0] out_sample;
    logic        flush;
    logic [6:0]  level;
    logic        nearly_full;
    logic        underrun;
    logic        overrun;
    logic        clear_flags;

    audiofifo_mc dut (
        .clk(clk), .reset_n(reset_n),
        .in_write(in_write), .in_sample(in_sample),
        .in_strobe(in_strobe), .out_write(out_write),
        .out_strobe(out_strobe), .out_sample(out_sample),
        .flush(flush), .level(level),
        .nearly_full(nearly_full), .underrun(underrun),
        .overrun(overrun), .clear_flags(clear_flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        int          e;
    } ent_t;

    ent_t mq[$];
    int   checks = 0;
    int   failures = 0;
    int   ecnt = 0;
    bit   obs_strobe, exp_strobe, exp_ow;
    bit   m_under, m_over, m_zero;

    // Frames become visible one edge after the edge that stored them.
    task automatic cycle(input bit w, input logic [31:0] d,
                         input bit rs, input bit fl, input bit cf);
        bit acc, xf, uev, oev;
        in_write = w; in_sample = d; out_strobe = rs;
        flush = fl; clear_flags = cf;
        #1;
        obs_strobe = in_strobe;
        acc = w && (mq.size() < AL) && !fl;
        exp_strobe = acc;
        xf  = exp_ow && rs && !fl;
        uev = rs && (mq.size() == 0);
        oev = w && !acc && !fl;
        @(posedge clk);
        ecnt++;
        if (fl) mq.delete();
        else begin
            if (xf) void'(mq.pop_front());
            if (acc) mq.push_back('{d, ecnt});
        end
        m_under = uev | (m_under & !cf);
        m_over  = oev | (m_over & !cf);
        exp_ow  = (mq.size() > 0) && (mq[0].e < ecnt);
        m_zero  = (m_zero | uev) & !exp_ow;
        #1;
    endtask

    task automatic do_reset();
        in_write = 0; in_sample = 0; out_strobe = 0;
        flush = 0; clear_flags = 0;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        mq.delete();
        exp_ow = 0; m_under = 0; m_over = 0; m_zero = 0;
        repeat (3) cycle(0, 32'h0, 0, 0, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && mq.size() > 0; i++)
            cycle(0, 32'h0, 1, 0, 0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_write = 1'b1; in_sample = 32'hFFFF_FFFF;
        out_strobe = 0; flush = 0; clear_flags = 0;
        #2;
        checks++;
        if ({in_strobe, out_write, nearly_full, underrun, overrun} !== 5'b0
            || level !== 7'd0 || out_sample !== 32'h0) begin
            failures++;
            $display("FAIL reset: strobe=%b ow=%b nf=%b ur=%b or=%b lvl=%0d out=%h want all 0",
                     in_strobe, out_write, nearly_full, underrun, overrun, level, out_sample);
        end
        @(posedge clk); #1;
        do_reset();
        checks++;
        if (level !== 7'd0 || out_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: lvl=%0d ow=%b want 0 0", level, out_write);
        end
    endtask

    task automatic test_passthrough();
        cycle(1, 32'h1234_ABCD, 0, 0, 0);
        checks++;
        if (out_write !== 1'b0 || level !== 7'd1) begin
            failures++;
            $display("FAIL pass_edge1: ow=%b lvl=%0d want 0 1", out_write, level);
        end
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (out_write !== 1'b1 || out_sample !== 32'h1234_ABCD || level !== 7'd1) begin
            failures++;
            $display("FAIL pass_edge2: ow=%b out=%h lvl=%0d want 1 1234abcd 1",
                     out_write, out_sample, level);
        end
        cycle(0, 32'h0, 1, 0, 0);
        checks++;
        if (out_write !== 1'b0 || level !== 7'd0) begin
            failures++;
            $display("FAIL pass_read: ow=%b lvl=%0d want 0 0", out_write, level);
        end
    endtask

    task automatic test_fill();
        int pre;
        for (int i = 0; i < 64; i++) begin
            pre = mq.size();
            cycle(1, $urandom, 0, 0, 0);
            checks++;
            if (obs_strobe !== (pre < AL)) begin
                failures++;
                $display("FAIL fill_strobe: lvl=%0d got %b want %b", pre, obs_strobe, pre < AL);
            end
            checks++;
            if (level !== 7'(mq.size()) || nearly_full !== (mq.size() >= NF)
                || overrun !== m_over) begin
                failures++;
                $display("FAIL fill_state: lvl=%0d nf=%b or=%b want %0d %b %b",
                         level, nearly_full, overrun, mq.size(), mq.size() >= NF, m_over);
            end
        end
        checks++;
        if (level !== 7'd60 || overrun !== 1'b1 || nearly_full !== 1'b1) begin
            failures++;
            $display("FAIL fill_end: lvl=%0d or=%b nf=%b want 60 1 1", level, overrun, nearly_full);
        end
        for (int i = 0; i < 200 && mq.size() > 0; i++) begin
            if (exp_ow) begin
                checks++;
                if (out_write !== 1'b1 || out_sample !== mq[0].d) begin
                    failures++;
                    $display("FAIL fill_drain: ow=%b out=%h want 1 %h", out_write, out_sample, mq[0].d);
                end
            end
            cycle(0, 32'h0, 1, 0, 0);
        end
        cycle(0, 32'h0, 0, 0, 1);
        checks++;
        if (overrun !== 1'b0 || level !== 7'd0) begin
            failures++;
            $display("FAIL fill_clear: or=%b lvl=%0d want 0 0", overrun, level);
        end
    endtask

    task automatic test_stream();
        repeat (10) cycle(1, $urandom, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (level !== 7'd10 || out_write !== 1'b1) begin
            failures++;
            $display("FAIL stream_prefill: lvl=%0d ow=%b want 10 1", level, out_write);
        end
        for (int i = 0; i < 200; i++) begin
            cycle(1, $urandom, 1, 0, 0);
            checks++;
            if (level !== 7'd10 || out_write !== 1'b1 || out_sample !== mq[0].d) begin
                failures++;
                $display("FAIL stream[%0d]: lvl=%0d ow=%b out=%h want 10 1 %h",
                         i, level, out_write, out_sample, mq[0].d);
            end
        end
        drain();
    endtask

    task automatic test_underrun();
        cycle(0, 32'h0, 1, 0, 0);
        checks++;
        if (underrun !== 1'b1 || out_sample !== 32'h0) begin
            failures++;
            $display("FAIL underrun_set: ur=%b out=%h want 1 0", underrun, out_sample);
        end
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (out_sample !== 32'h0 || out_write !== 1'b0) begin
            failures++;
            $display("FAIL underrun_hold0: out=%h ow=%b want 0 0", out_sample, out_write);
        end
        cycle(0, 32'h0, 1, 0, 1);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_setwins: ur=%b want 1", underrun);
        end
        cycle(0, 32'h0, 0, 0, 1);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL underrun_clear: ur=%b want 0", underrun);
        end
        cycle(1, 32'h5A5A_0F0F, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (out_write !== 1'b1 || out_sample !== 32'h5A5A_0F0F) begin
            failures++;
            $display("FAIL underrun_recover: ow=%b out=%h want 1 5a5a0f0f", out_write, out_sample);
        end
        drain();
    endtask

    task automatic test_flush();
        repeat (30) cycle(1, $urandom, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        cycle(1, $urandom, 1, 1, 0);
        checks++;
        if (level !== 7'd0 || out_write !== 1'b0 || obs_strobe !== 1'b0) begin
            failures++;
            $display("FAIL flush: lvl=%0d ow=%b strobe=%b want 0 0 0", level, out_write, obs_strobe);
        end
        cycle(1, 32'hCAFE_F00D, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (out_write !== 1'b1 || out_sample !== 32'hCAFE_F00D || level !== 7'd1) begin
            failures++;
            $display("FAIL flush_next: ow=%b out=%h lvl=%0d want 1 cafef00d 1",
                     out_write, out_sample, level);
        end
        drain();
    endtask

    task automatic test_random();
        bit w, rs, fl, cf;
        int pw;
        for (int i = 0; i < 800; i++) begin
            pw = (i % 200 < 100) ? 75 : 35;
            w  = $urandom_range(0, 99) < pw;
            rs = $urandom_range(0, 99) < 50;
            fl = $urandom_range(0, 99) < 2;
            cf = $urandom_range(0, 99) < 4;
            cycle(w, $urandom, rs, fl, cf);
            checks++;
            if (obs_strobe !== exp_strobe || level !== 7'(mq.size())
                || out_write !== exp_ow || nearly_full !== (mq.size() >= NF)
                || underrun !== m_under || overrun !== m_over) begin
                failures++;
                $display("FAIL rand[%0d]: st=%b lvl=%0d ow=%b nf=%b ur=%b or=%b want %b %0d %b %b %b %b",
                         i, obs_strobe, level, out_write, nearly_full, underrun, overrun,
                         exp_strobe, mq.size(), exp_ow, mq.size() >= NF, m_under, m_over);
            end
            if (exp_ow) begin
                checks++;
                if (out_sample !== mq[0].d) begin
                    failures++;
                    $display("FAIL rand_data[%0d]: out=%h want %h", i, out_sample, mq[0].d);
                end
            end else if (m_zero) begin
                checks++;
                if (out_sample !== 32'h0) begin
                    failures++;
                    $display("FAIL rand_zero[%0d]: out=%h want 0", i, out_sample);
                end
            end
        end
        drain();
    endtask

    task automatic test_async_reset();
        repeat (61) cycle(1, $urandom, 0, 0, 0);
        checks++;
        if (overrun !== 1'b1 || nearly_full !== 1'b1 || out_write !== 1'b1) begin
            failures++;
            $display("FAIL arst_pre: or=%b nf=%b ow=%b want 1 1 1", overrun, nearly_full, out_write);
        end
        in_write = 1'b1; out_strobe = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({in_strobe, out_write, nearly_full, underrun, overrun} !== 5'b0
            || level !== 7'd0 || out_sample !== 32'h0) begin
            failures++;
            $display("FAIL arst: strobe=%b ow=%b nf=%b ur=%b or=%b lvl=%0d out=%h want all 0",
                     in_strobe, out_write, nearly_full, underrun, overrun, level, out_sample);
        end
        do_reset();
        cycle(1, 32'h0BAD_BEEF, 0, 0, 0);
        cycle(0, 32'h0, 0, 0, 0);
        checks++;
        if (out_write !== 1'b1 || out_sample !== 32'h0BAD_BEEF || level !== 7'd1) begin
            failures++;
            $display("FAIL arst_after: ow=%b out=%h lvl=%0d want 1 0badbeef 1",
                     out_write, out_sample, level);
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fill();
        test_stream();
        test_underrun();
        test_flush();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/audiofifo_mc.md
AUDIOFIFO_MC -- requirements
Module: audiofifo_mc

Interface
REQ-001 Parameter WIDTH, default 16, meaning bits per signed sample.
REQ-002 Parameter CHANNELS, default 2, meaning samples per frame; one FIFO entry holds one frame.
REQ-003 Parameter DEPTH, default 64, meaning frame capacity; power of two, at least 4.
REQ-004 Parameter ACCEPT_LIMIT, default DEPTH-4, meaning the level at and above which input is refused.
REQ-005 Parameter NEARLY_FULL_LEVEL, default 48, meaning the level at and above which nearly_full is asserted.
REQ-006 Parameter ZERO_ON_EMPTY, default 1, meaning out_sample is forced to 0 after an underrun; when 0, the last sample is held instead.
REQ-007 Port clk, input, 1 bit, the single clock; all logic is clocked on the rising edge.
REQ-008 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-009 Port in_write, input, 1 bit, source offers a frame.
REQ-010 Port in_sample, input, CHANNELS*WIDTH bits, frame with channel 0 in the LSBs.
REQ-011 Port in_strobe, output, 1 bit, frame accepted this cycle.
REQ-012 Port out_write, output, 1 bit, out_sample is valid.
REQ-013 Port out_strobe, input, 1 bit, sink consumes the frame.
REQ-014 Port out_sample, output, CHANNELS*WIDTH bits, registered output frame.
REQ-015 Port flush, input, 1 bit, synchronous discard of all contents.
REQ-016 Port level, output, clog2(DEPTH)+1 bits, current frame count.
REQ-017 Port nearly_full, output, 1 bit, level >= NEARLY_FULL_LEVEL.
REQ-018 Port underrun, output, 1 bit, sticky flag set by a strobe while empty.
REQ-019 Port overrun, output, 1 bit, sticky flag set by in_write refused while not flushing.
REQ-020 Port clear_flags, input, 1 bit, clears underrun and overrun.

Function
REQ-021 in_strobe SHALL be in_write && level < ACCEPT_LIMIT && !flush, combinational.
REQ-022 A frame SHALL transfer on the output only when out_write && out_strobe are both high in the same cycle; out_strobe without out_write SHALL NOT alter state.
REQ-023 Storage SHALL be a synchronous-read RAM of DEPTH x CHANNELS*WIDTH; read and write indices SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-024 The read address SHALL be the look-ahead index: the index incremented by one when a transfer occurs in the current cycle; out_sample SHALL register mem[look-ahead index] on every edge.
REQ-025 A frame written at edge N SHALL first be presented with out_write high after edge N+1; out_write SHALL be suppressed for one cycle whenever the look-ahead index equals the write index during a write.
REQ-026 level SHALL increment on an accept without a transfer, decrement on a transfer without an accept, and remain unchanged when both or neither occur.
REQ-027 Full sustained throughput SHALL be one frame per cycle in each direction when the FIFO is non-empty and below ACCEPT_LIMIT.
REQ-028 flush SHALL, at the next edge, set level to 0, set the write index to the read index, and drop out_write; flush SHALL take priority over a simultaneous accept and transfer.
REQ-029 underrun SHALL set at the edge following out_strobe && level==0; overrun SHALL set at the edge following in_write && !in_strobe && !flush.
REQ-030 clear_flags SHALL clear both flags at the next edge; a simultaneous set condition SHALL take priority over the clear.
REQ-031 After an underrun, with ZERO_ON_EMPTY=1, out_sample SHALL read 0 until the next valid frame; with ZERO_ON_EMPTY=0, out_sample SHALL keep its last value.
REQ-032 The nearly_full, underrun and overrun outputs SHALL be glitch-free functions of registered state.

Reset
REQ-033 reset_n low SHALL asynchronously clear the indices, level, underrun, overrun and out_sample to 0, giving out_write=0, in_strobe=0 and nearly_full=0.
REQ-034 RAM contents SHALL NOT be reset; reset asserted mid-transfer SHALL discard all frames, and deassertion SHALL be synchronised to clk.

Verification
REQ-035 Empty pass-through: write 0x1234_ABCD once -> out_write rises after 2 edges with out_sample=0x1234_ABCD, and level=1.
REQ-036 Fill: in_write held with DEPTH=64 and no reads -> in_strobe drops at level 60; nearly_full is high from level 48; one refused cycle sets overrun.
REQ-037 Streaming: simultaneous write and read at level 10 for 200 cycles -> level stays 10 and data ordering is preserved across index wrap.
REQ-038 Underrun: out_strobe while empty -> underrun=1 and out_sample=0 (ZERO_ON_EMPTY=1); clear_flags -> 0.
REQ-039 Flush at level 30 with concurrent write and read -> level=0 and out_write=0 next cycle; the next written frame is output correctly.
REQ-040 Async reset pulsed mid-stream between edges -> all outputs are 0 immediately, without waiting for a clock edge.
